// File: rtl/wb_commit_if.sv
// Writeback commit bus: ALU/load/memory inputs, ID-stage hazard queries and the
// register-file write port. The slave modport is the wb_commit side.
interface wb_commit_if #(
  parameter int NUM_DOMAINS = 1
);
  localparam int DW = NUM_DOMAINS * 8;

  logic          alu_valid;
  logic [3:0]    alu_dest;
  logic [DW-1:0] alu_data;
  logic          ld_issue;
  logic [3:0]    ld_dest;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic [3:0]    query_addr1;
  logic [3:0]    query_addr2;
  logic          load_hazard;
  logic          stall;
  logic          reg_wr_en;
  logic [3:0]    destination_reg_addr;
  logic [DW-1:0] wr_data;
  logic          wb_err;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output ld_issue, ld_dest,
    output mem_rd_valid, mem_rd_data,
    output query_addr1, query_addr2,
    input  load_hazard, stall,
    input  reg_wr_en, destination_reg_addr, wr_data,
    input  wb_err
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  ld_issue, ld_dest,
    input  mem_rd_valid, mem_rd_data,
    input  query_addr1, query_addr2,
    output load_hazard, stall,
    output reg_wr_en, destination_reg_addr, wr_data,
    output wb_err
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback commit unit: pending-load queue, load/ALU write-port arbitration with a
// one-entry ALU skid buffer. Define WB_ERR_CHECK_EN to build the sticky wb_err flag.
module wb_commit #(
  parameter int NUM_DOMAINS = 1,
  parameter int LDQ_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  wb_commit_if.slave  bus
);
  localparam int DW = NUM_DOMAINS * 8;
  localparam int PW = $clog2(LDQ_DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    ldq_q [LDQ_DEPTH];
  logic [3:0]    ldq_d [LDQ_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          skid_valid_q, skid_valid_d;
  logic [3:0]    skid_dest_q, skid_dest_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  logic          reg_wr_en_q, reg_wr_en_d;
  logic [3:0]    dest_q, dest_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          full_s;
  logic          empty_s;
  logic          ld_pop_s;
  logic          ld_push_s;
  logic          load_hazard_s;

  assign full_s    = (count_q == CW'(LDQ_DEPTH));
  assign empty_s   = (count_q == {CW{1'b0}});
  assign ld_pop_s  = bus.mem_rd_valid & ~empty_s;
  // A simultaneous pop frees the head slot, so a push into a full queue is legal then.
  assign ld_push_s = bus.ld_issue & (~full_s | ld_pop_s);

  always_comb begin
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      ldq_d[i] = ldq_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (ld_push_s) begin
      ldq_d[tail_q] = bus.ld_dest;
      tail_d        = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (ld_pop_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    case ({ld_push_s, ld_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    reg_wr_en_d  = 1'b0;
    dest_d       = dest_q;
    wr_data_d    = wr_data_q;
    skid_valid_d = skid_valid_q;
    skid_dest_d  = skid_dest_q;
    skid_data_d  = skid_data_q;
    if (ld_pop_s) begin
      reg_wr_en_d = 1'b1;
      dest_d      = ldq_q[head_q];
      wr_data_d   = bus.mem_rd_data;
      // An occupied skid keeps its older result; a new ALU result is then lost.
      if (bus.alu_valid && !skid_valid_q) begin
        skid_valid_d = 1'b1;
        skid_dest_d  = bus.alu_dest;
        skid_data_d  = bus.alu_data;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (skid_valid_q) begin
      reg_wr_en_d = 1'b1;
      dest_d      = skid_dest_q;
      wr_data_d   = skid_data_q;
      if (bus.alu_valid) begin
        skid_valid_d = 1'b1;
        skid_dest_d  = bus.alu_dest;
        skid_data_d  = bus.alu_data;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else if (bus.alu_valid) begin
      reg_wr_en_d = 1'b1;
      dest_d      = bus.alu_dest;
      wr_data_d   = bus.alu_data;
    end else begin
      reg_wr_en_d = 1'b0;
    end
  end

  // Entry i is live when its distance from the head is below the occupancy count.
  always_comb begin
    load_hazard_s = 1'b0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (({1'b0, PW'(i) - head_q} < count_q) &&
          ((ldq_q[i] == bus.query_addr1) || (ldq_q[i] == bus.query_addr2))) begin
        load_hazard_s = 1'b1;
      end else begin
        load_hazard_s = load_hazard_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        ldq_q[i] <= 4'h0;
      end
      head_q       <= {PW{1'b0}};
      tail_q       <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      skid_valid_q <= 1'b0;
      skid_dest_q  <= 4'h0;
      skid_data_q  <= {DW{1'b0}};
      reg_wr_en_q  <= 1'b0;
      dest_q       <= 4'h0;
      wr_data_q    <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        ldq_q[i] <= ldq_d[i];
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      skid_valid_q <= skid_valid_d;
      skid_dest_q  <= skid_dest_d;
      skid_data_q  <= skid_data_d;
      reg_wr_en_q  <= reg_wr_en_d;
      dest_q       <= dest_d;
      wr_data_q    <= wr_data_d;
    end
  end

`ifdef WB_ERR_CHECK_EN
  logic err_event_s;
  logic wb_err_q, wb_err_d;

  assign err_event_s = (bus.mem_rd_valid & empty_s)
                     | (bus.ld_issue & full_s & ~ld_pop_s)
                     | (bus.alu_valid & skid_valid_q & ld_pop_s);

  always_comb begin
    wb_err_d = wb_err_q | err_event_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end

  assign bus.wb_err = wb_err_q;
`else
  assign bus.wb_err = 1'b0;
`endif

  assign bus.stall                = skid_valid_q | full_s;
  assign bus.load_hazard          = load_hazard_s;
  assign bus.reg_wr_en            = reg_wr_en_q;
  assign bus.destination_reg_addr = dest_q;
  assign bus.wr_data              = wr_data_q;
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: stimulus pushes expected register writes into a
// scoreboard queue; a negedge monitor pops and compares each write strobe.
module tb_wb_commit;
  logic clk;
  logic reset;

  wb_commit_if #(.NUM_DOMAINS(1)) bus ();

  wb_commit #(.NUM_DOMAINS(1), .LDQ_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef WB_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [11:0] exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Write-port monitor: every strobe must match the oldest expected write.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (bus.reg_wr_en === 1'b1) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   bus.destination_reg_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.destination_reg_addr, bus.wr_data} !== e) begin
            $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                     bus.destination_reg_addr, bus.wr_data, e[11:8], e[7:0]);
          end else begin
            n_pass++;
          end
        end
      end
    end
  end

  task automatic clear_in();
    bus.alu_valid    = 1'b0;
    bus.alu_dest     = 4'h0;
    bus.alu_data     = 8'h00;
    bus.ld_issue     = 1'b0;
    bus.ld_dest      = 4'h0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 8'h00;
    bus.query_addr1  = 4'h0;
    bus.query_addr2  = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic alu(input logic [3:0] d, input logic [7:0] v);
    bus.alu_valid = 1'b1;
    bus.alu_dest  = d;
    bus.alu_data  = v;
  endtask

  task automatic issue(input logic [3:0] d);
    bus.ld_issue = 1'b1;
    bus.ld_dest  = d;
  endtask

  task automatic ret(input logic [7:0] v);
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = v;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("reset_wr_en", bus.reg_wr_en, 1'b0);
    chk("reset_addr", bus.destination_reg_addr, 4'h0);
    chk("reset_data", bus.wr_data, 8'h00);
    chk("reset_stall", bus.stall, 1'b0);
    chk("reset_err", bus.wb_err, 1'b0);

    // ALU only
    alu(4'd5, 8'h3C);
    exp_q.push_back({4'd5, 8'h3C});
    settle();
    chk("alu_stall", bus.stall, 1'b0);
    tick();
    // register 0 written normally
    alu(4'd0, 8'hFF);
    exp_q.push_back({4'd0, 8'hFF});
    tick();

    // load then hazard
    issue(4'd7);
    tick();
    bus.query_addr1 = 4'd7;
    settle();
    chk("hazard_pending", bus.load_hazard, 1'b1);
    ret(8'hA5);
    exp_q.push_back({4'd7, 8'hA5});
    settle();
    chk("hazard_return_cycle", bus.load_hazard, 1'b1);
    tick();
    bus.query_addr1 = 4'd7;
    settle();
    chk("hazard_after_pop", bus.load_hazard, 1'b0);
    tick();

    // collision: load return beats ALU, ALU goes to skid
    issue(4'd2);
    tick();
    ret(8'h11);
    alu(4'd4, 8'h22);
    exp_q.push_back({4'd2, 8'h11});
    exp_q.push_back({4'd4, 8'h22});
    settle();
    chk("coll_stall_before", bus.stall, 1'b0);
    tick();
    settle();
    chk("coll_stall_skid", bus.stall, 1'b1);
    tick();
    settle();
    chk("coll_stall_after", bus.stall, 1'b0);
    chk("coll_err", bus.wb_err, 1'b0);

    // skid held across back-to-back load returns
    issue(4'd12);
    tick();
    issue(4'd13);
    tick();
    ret(8'h01);
    alu(4'd14, 8'h02);
    exp_q.push_back({4'd12, 8'h01});
    tick();
    ret(8'h03);
    exp_q.push_back({4'd13, 8'h03});
    tick();
    exp_q.push_back({4'd14, 8'h02});
    tick();
    settle();
    chk("b2b_stall_after", bus.stall, 1'b0);

    // LDQ full, push+pop while full, overflow
    issue(4'd1);
    tick();
    issue(4'd3);
    tick();
    settle();
    chk("full_stall", bus.stall, 1'b1);
    issue(4'd9);
    ret(8'h41);
    exp_q.push_back({4'd1, 8'h41});
    tick();
    bus.query_addr1 = 4'd9;
    bus.query_addr2 = 4'd3;
    settle();
    chk("pushpop_stall", bus.stall, 1'b1);
    chk("pushpop_err", bus.wb_err, 1'b0);
    chk("pushpop_hazard_new", bus.load_hazard, 1'b1);
    bus.query_addr1 = 4'd1;
    bus.query_addr2 = 4'd0;
    settle();
    chk("pushpop_hazard_popped", bus.load_hazard, 1'b0);
    issue(4'd6);
    tick();
    bus.query_addr1 = 4'd6;
    settle();
    chk("overflow_err", bus.wb_err, EXP_ERR);
    chk("overflow_dropped", bus.load_hazard, 1'b0);
    ret(8'h42);
    exp_q.push_back({4'd3, 8'h42});
    tick();
    ret(8'h43);
    exp_q.push_back({4'd9, 8'h43});
    tick();
    settle();
    chk("drain_stall", bus.stall, 1'b0);

    // reset with one pending load and the skid occupied
    issue(4'd8);
    tick();
    issue(4'd10);
    tick();
    ret(8'h55);
    alu(4'd11, 8'h66);
    exp_q.push_back({4'd8, 8'h55});
    tick();
    bus.query_addr1 = 4'd10;
    settle();
    chk("pre_reset_stall", bus.stall, 1'b1);
    chk("pre_reset_hazard", bus.load_hazard, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.query_addr1 = 4'd10;
    settle();
    chk("mid_reset_wr_en", bus.reg_wr_en, 1'b0);
    chk("mid_reset_addr", bus.destination_reg_addr, 4'h0);
    chk("mid_reset_data", bus.wr_data, 8'h00);
    chk("mid_reset_stall", bus.stall, 1'b0);
    chk("mid_reset_hazard", bus.load_hazard, 1'b0);
    chk("mid_reset_err", bus.wb_err, 1'b0);
    ret(8'h77);
    tick();
    settle();
    chk("stale_return_err", bus.wb_err, EXP_ERR);
    tick();
    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
